// File: rtl/ac_match_engine_if.sv
// Character stream handshake between the character source and the
// Aho-Corasick match engine.
interface ac_match_engine_if #(
    parameter int CHAR_W = 4
);
    logic              ch_valid;
    logic [CHAR_W-1:0] ch_data;
    logic              ch_ready;

    modport master (
        output ch_valid,
        output ch_data,
        input  ch_ready
    );

    modport slave (
        input  ch_valid,
        input  ch_data,
        output ch_ready
    );
endinterface

// File: rtl/ac_match_engine.sv
// Aho-Corasick stepping engine: walks a runtime-loaded goto table one entry per
// cycle, following the failure chain on a miss, and flags hits with the stream position.
module ac_match_engine #(
    parameter int STATE_W    = 8,
    parameter int CHAR_W     = 4,
    parameter int GOTO_DEPTH = 32,
    parameter int NSTATES    = 32,
    parameter int POS_W      = 16,
    localparam int GW        = $clog2(GOTO_DEPTH),
    localparam int NW        = $clog2(NSTATES),
    localparam int AW        = (GW > NW) ? GW : NW,
    localparam int DW        = 2*STATE_W + CHAR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [DW-1:0]      cfg_data,
    input  logic               soft_clr,
    ac_match_engine_if.slave   ch,
    output logic               busy,
    output logic [STATE_W-1:0] now_state,
    output logic               match_valid,
    output logic [STATE_W-1:0] match_state,
    output logic [POS_W-1:0]   match_pos,
    output logic               err
);

    localparam int HW = $clog2(NSTATES + 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t              state;
    logic                ready_q;
    logic [CHAR_W-1:0]   char_q;
    logic [GW-1:0]       idx;
    logic [HW-1:0]       hops;
    logic [POS_W-1:0]    pos;

    logic                goto_vld [GOTO_DEPTH];
    logic [STATE_W-1:0]  goto_cur [GOTO_DEPTH];
    logic [CHAR_W-1:0]   goto_chr [GOTO_DEPTH];
    logic [STATE_W-1:0]  goto_nxt [GOTO_DEPTH];
    logic [STATE_W-1:0]  fail_tbl [NSTATES];
    logic                out_flag [NSTATES];

    logic                entry_hit;
    logic                last_entry;
    logic                finish;
    logic                hop_err;
    logic [STATE_W-1:0]  final_state;

    assign ch.ch_ready = ready_q;

    // Table writes are only honoured while idle so a scan never sees a half-updated automaton.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GOTO_DEPTH; i++) begin
                goto_vld[i] <= 1'b0;
                goto_cur[i] <= '0;
                goto_chr[i] <= '0;
                goto_nxt[i] <= '0;
            end
            for (int i = 0; i < NSTATES; i++) begin
                fail_tbl[i] <= '0;
                out_flag[i] <= 1'b0;
            end
        end else if (cfg_we && !busy) begin
            if (!cfg_sel) begin
                goto_vld[cfg_addr[GW-1:0]] <= cfg_data[DW-1];
                goto_cur[cfg_addr[GW-1:0]] <= cfg_data[STATE_W+CHAR_W +: STATE_W];
                goto_chr[cfg_addr[GW-1:0]] <= cfg_data[STATE_W +: CHAR_W];
                goto_nxt[cfg_addr[GW-1:0]] <= cfg_data[STATE_W-1:0];
            end else begin
                fail_tbl[cfg_addr[NW-1:0]] <= cfg_data[STATE_W-1:0];
                out_flag[cfg_addr[NW-1:0]] <= cfg_data[STATE_W];
            end
        end
    end

    assign entry_hit  = goto_vld[idx] && (goto_cur[idx] == now_state) &&
                        (goto_chr[idx] == char_q);
    assign last_entry = (idx == GW'(GOTO_DEPTH - 1));

    // Decide whether the current compare finishes the character and where it lands.
    always_comb begin
        finish      = 1'b0;
        hop_err     = 1'b0;
        final_state = now_state;
        if (state == SCAN) begin
            if (entry_hit) begin
                finish      = 1'b1;
                final_state = goto_nxt[idx];
            end else if (last_entry) begin
                if (now_state == '0) begin
                    finish      = 1'b1;
                    final_state = '0;
                end else if (hops == HW'(NSTATES)) begin
                    finish      = 1'b1;
                    hop_err     = 1'b1;
                    final_state = '0;
                end
            end
        end
    end

    // Main FSM; a soft clear wins over everything, including an accept in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            busy        <= 1'b0;
            char_q      <= '0;
            idx         <= '0;
            hops        <= '0;
            pos         <= '0;
            now_state   <= '0;
            match_valid <= 1'b0;
            match_state <= '0;
            match_pos   <= '0;
            err         <= 1'b0;
        end else begin
            match_valid <= 1'b0;
            if (soft_clr) begin
                state     <= IDLE;
                ready_q   <= 1'b1;
                busy      <= 1'b0;
                now_state <= '0;
                pos       <= '0;
                err       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ch.ch_valid) begin
                            char_q  <= ch.ch_data;
                            idx     <= '0;
                            hops    <= '0;
                            state   <= SCAN;
                            ready_q <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (finish) begin
                            now_state <= final_state;
                            pos       <= pos + POS_W'(1);
                            if (hop_err) begin
                                err <= 1'b1;
                            end
                            if (out_flag[final_state[NW-1:0]]) begin
                                match_valid <= 1'b1;
                                match_state <= final_state;
                                match_pos   <= pos;
                            end
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            busy    <= 1'b0;
                        end else if (last_entry) begin
                            now_state <= fail_tbl[now_state[NW-1:0]];
                            hops      <= hops + HW'(1);
                            idx       <= '0;
                        end else begin
                            idx <= idx + GW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ac_match_engine.md
Name: ac_match_engine

Overview:
- Parametrised Aho-Corasick stepping engine; next generation of the single-step goto/failure table reader.
- Consumes a character stream over a valid/ready handshake and walks the goto table once per character, following the failure chain on a miss.
- Reports pattern hits from a per-state output flag, with the stream position.
- Tables are runtime-loadable through a config write port; sits between the character source and the match-report logic.

Parameters:
- STATE_W, 8, state number width.
- CHAR_W, 4, character width.
- GOTO_DEPTH, 32, goto table entries; power of 2.
- NSTATES, 32, failure/output table entries; power of 2, at most 2**STATE_W.
- POS_W, 16, stream position counter width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous active-low reset.
- CFG_WE  in  1  table write strobe; ignored while BUSY=1.
- CFG_SEL  in  1  0 = goto entry, 1 = failure/output entry.
- CFG_ADDR  in  log2(max(GOTO_DEPTH,NSTATES))  entry index; upper bits ignored for the smaller table.
- CFG_DATA  in  2*STATE_W+CHAR_W+1  SEL=0: {valid, cur_state, chara, next_state}; SEL=1: low STATE_W+1 bits = {out_flag, fail_state}.
- SOFT_CLR  in  1  synchronous clear of NOW_STATE, position and ERR; tables are kept.
- CH_VALID  in  1  character valid.
- CH_DATA  in  CHAR_W  character.
- CH_READY  out  1  engine can accept a character (IDLE).
- BUSY  out  1  engine is in SCAN.
- NOW_STATE  out  STATE_W  automaton state after the last completed character.
- MATCH_VALID  out  1  one-cycle pulse: the completed state has out_flag=1.
- MATCH_STATE  out  STATE_W  state that produced the hit.
- MATCH_POS  out  POS_W  0-based index of the character that completed the hit.
- ERR  out  1  sticky; the failure chain exceeded NSTATES hops.

Behaviour:
- Reset (RST=0, async):
  - FSM goes to IDLE; NOW_STATE, position, idx, hop count = 0.
  - MATCH_VALID, MATCH_STATE, MATCH_POS, ERR, BUSY = 0; CH_READY = 1.
  - All goto valid bits, failure entries and out_flags cleared.
- IDLE:
  - CH_READY=1.
  - CH_VALID=1 at edge T: latch the character, idx=0, hop count=0, go to SCAN.
  - CFG_WE writes the addressed entry at the edge.
  - SOFT_CLR has priority over an accept in the same cycle; the character is not consumed.
- SCAN, one goto entry compared per cycle:
  - Entry i of a pass is compared in cycle T+1+i.
  - Hit when valid=1, cur_state==NOW_STATE and chara==char.
  - Hit: NOW_STATE<=next_state; go to IDLE.
  - Miss on the last entry (idx=GOTO_DEPTH-1):
    - If NOW_STATE==0, stay at state 0 (character done); go to IDLE.
    - Otherwise NOW_STATE<=fail[NOW_STATE], hop count+1, idx=0, start a new pass.
  - If hop count would exceed NSTATES: set ERR, force NOW_STATE=0, character done.
  - Best case latency (hit on entry 0 of pass 0): CH_READY returns at T+2.
  - Latency for a hit at entry i in pass p: p*GOTO_DEPTH+i+2 cycles.
- Character completion (same edge NOW_STATE takes its final value):
  - Position increments by 1 and wraps modulo 2**POS_W.
  - If out_flag[new state]=1: MATCH_VALID=1 for exactly that cycle, with MATCH_STATE=new state and MATCH_POS=pre-increment position.
  - Otherwise MATCH_VALID=0; MATCH_STATE and MATCH_POS hold their previous values.
- Table addressing: failure/out_flag reads index with NOW_STATE modulo NSTATES.
- Duplicate goto hits: the lowest-index matching entry wins.
- RST asserted mid-SCAN aborts the character; no MATCH is issued.
- CH_VALID held high while busy is not consumed until CH_READY=1.

Test Plan:
- Reset with CH_VALID=1 → CH_READY=1, NOW_STATE=0, MATCH_VALID=0, ERR=0; empty tables, char 7 → state 0, no MATCH, CH_READY back after 33 cycles.
- Load "he, she, his, hers" (h=1 e=2 s=3 i=4 r=5):
  - Goto: 0h1 1e2 0s3 3h4 4e5 1i6 6s7 2r8 8s9.
  - Fail: 4→1, 5→2, 7→3, 9→3, others 0.
  - out_flag set on states 2, 5, 7, 9.
  - Stream "ushers" (u=6) → states 0, 3, 4, 5, 8, 9; MATCH (state 5, pos 3) and (state 9, pos 5).
- Hit on goto entry 0 → CH_READY deasserted exactly one cycle, MATCH one cycle after accept edge+1.
- Failure loop: table with fail[1]=2, fail[2]=1, no goto from 1/2, state 1, char 5 → ERR=1, NOW_STATE=0 after NSTATES+1 passes.
- SOFT_CLR in the same cycle as CH_VALID → char not accepted, NOW_STATE=0, position 0; CFG_WE while BUSY → table unchanged.
- Position wrap with POS_W=4: 17 chars matching state 2 each → MATCH_POS sequence wraps 15→0.
